fanout_fork_ctrl: RTL and testbench

Registered one-to-many fork controller for the sparse-accelerator tile streams. It takes one ready/valid producer stream and delivers each token exactly once to every destination enabled in a configured mask. It tracks per-destination acceptance across cycles, and returns ready to the producer only when every enabled destination has taken the token. It sits between a primitive's output stream and the fanout routing, and replaces the purely combinational ready-merge: it adds a one-entry buffer, partial-acceptance tracking, configuration and stall monitoring.

---
 rtl/fanout_pkg.sv | 16 +
 rtl/fanout_ready_merge.sv | 14 +
 rtl/fanout_fork_ctrl.sv | 147 ++++++++++++++
 tb/tb_fanout_fork_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fanout_pkg.sv
// Shared types and default parameters for the fanout fork controller.
package fanout_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } fork_state_t;

    localparam int NUM_OUT_DEF = 7;
    localparam int DATA_W_DEF  = 17;
    localparam int STALL_W_DEF = 16;

    // Sliced to NUM_OUT bits by users; every destination enabled out of reset.
    localparam logic [15:0] RESET_MASK = 16'hFFFF;

endpackage

// File: rtl/fanout_ready_merge.sv
// Combinational merge: a token is complete once every still-pending destination is ready.
module fanout_ready_merge
    import fanout_pkg::*;
#(
    parameter int NUM_OUT = NUM_OUT_DEF
) (
    input  logic [NUM_OUT-1:0] pending,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic               complete
);

    assign complete = &(~pending | out_ready);

endmodule

// File: rtl/fanout_fork_ctrl.sv
// Registered one-to-many fork: buffers one token and delivers it exactly once to each
// enabled destination, tracking partial acceptance, config writes and stall cycles.
module fanout_fork_ctrl
    import fanout_pkg::*;
#(
    parameter int NUM_OUT = NUM_OUT_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int STALL_W = STALL_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic               flush,
    input  logic               cfg_wr,
    input  logic [NUM_OUT-1:0] cfg_mask,
    output logic [NUM_OUT-1:0] cfg_mask_q,
    output logic               cfg_err,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic [NUM_OUT-1:0] out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic               busy,
    output logic [STALL_W-1:0] stall_cnt
);

    fork_state_t        state;
    fork_state_t        next_state;
    logic [NUM_OUT-1:0] done;
    logic [NUM_OUT-1:0] mask_q;
    logic [DATA_W-1:0]  data_q;
    logic [STALL_W-1:0] stall_q;
    logic               err_q;
    logic               active;
    logic               complete;
    logic               load;
    logic [NUM_OUT-1:0] hs;

    // Flush and a disabled clock both suppress every handshake in that cycle.
    assign active = clk_en & ~flush;

    fanout_ready_merge #(
        .NUM_OUT (NUM_OUT)
    ) u_merge (
        .pending   (~done),
        .out_ready (out_ready),
        .complete  (complete)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        if (flush) begin
            next_state = EMPTY;
        end else if (clk_en) begin
            case (state)
                EMPTY: begin
                    if (in_valid && (mask_q != '0)) begin
                        load       = 1'b1;
                        next_state = FULL;
                    end
                end
                FULL: begin
                    if (complete) begin
                        if (in_valid) begin
                            load = 1'b1;
                        end else begin
                            next_state = EMPTY;
                        end
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = '0;
        if (active) begin
            case (state)
                EMPTY: in_ready = 1'b1;
                FULL: begin
                    in_ready  = complete;
                    out_valid = ~done;
                end
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign hs = out_valid & out_ready;

    // The mask only changes while idle so an in-flight token never sees its targets move.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done    <= '0;
            data_q  <= '0;
            mask_q  <= RESET_MASK[NUM_OUT-1:0];
            err_q   <= 1'b0;
            stall_q <= '0;
        end else if (flush) begin
            done    <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else if (clk_en) begin
            if (load) begin
                data_q <= in_data;
                done   <= ~mask_q;
            end else if (state == FULL) begin
                done <= (next_state == EMPTY) ? '0 : (done | hs);
            end

            if (cfg_wr) begin
                if (state == EMPTY) begin
                    mask_q <= cfg_mask;
                end else begin
                    err_q <= 1'b1;
                end
            end

            if ((state == FULL) && (next_state == FULL) && (hs == '0)) begin
                if (stall_q != '1) begin
                    stall_q <= stall_q + STALL_W'(1);
                end
            end else begin
                stall_q <= '0;
            end
        end
    end

    assign cfg_mask_q = mask_q;
    assign cfg_err    = err_q;
    assign out_data   = data_q;
    assign busy       = (state == FULL);
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// Self-checking bench for fanout_fork_ctrl: vector table plus a token scoreboard.
module tb_fanout_fork_ctrl;

    localparam int NO = 7;
    localparam int DW = 17;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_en;
    logic          flush;
    logic          cfg_wr;
    logic [NO-1:0] cfg_mask;
    logic [NO-1:0] cfg_mask_q;
    logic          cfg_err;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [NO-1:0] out_valid;
    logic [DW-1:0] out_data;
    logic [NO-1:0] out_ready;
    logic          busy;
    logic [SW-1:0] stall_cnt;

    typedef struct {
        logic [DW-1:0] data;
        logic [NO-1:0] mask;
    } tok_t;

    typedef struct {
        logic          iv;
        logic [DW-1:0] data;
        logic [NO-1:0] ordy;
        logic          ce;
        logic          exp_ir;
        logic [NO-1:0] exp_ov;
        logic          exp_busy;
        logic [SW-1:0] exp_stall;
    } vec_t;

    tok_t          sb_q[$];
    vec_t          vecs[15];
    logic [NO-1:0] got;
    logic [NO-1:0] tb_mask;
    int            hs_total;
    int            accepted;
    int            checks;
    int            errors;

    fanout_fork_ctrl #(
        .NUM_OUT (NO),
        .DATA_W  (DW),
        .STALL_W (SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .flush      (flush),
        .cfg_wr     (cfg_wr),
        .cfg_mask   (cfg_mask),
        .cfg_mask_q (cfg_mask_q),
        .cfg_err    (cfg_err),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [DW-1:0] d,
                                 input logic [NO-1:0] ordy, input logic ce);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        clk_en    = ce;
        #1;
    endtask

    // Score handshakes seen just before the edge, record accepted tokens, then advance.
    task automatic tick();
        logic [NO-1:0] hs;
        tok_t          t;
        hs = out_valid & out_ready;
        if (hs != '0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected_handshake: got 0x%0h, expected none", hs);
            end else begin
                checkOutput("sb_out_data", out_data, sb_q[0].data);
                checkOutput("sb_dup_handshake", hs & got, 0);
                got      = got | hs;
                hs_total = hs_total + $countones(hs);
                if (got == sb_q[0].mask) begin
                    void'(sb_q.pop_front());
                    got = '0;
                end
            end
        end
        if (flush) begin
            sb_q.delete();
            got = '0;
        end else if (clk_en && in_valid && in_ready) begin
            accepted++;
            if (tb_mask != '0) begin
                t.data = in_data;
                t.mask = tb_mask;
                sb_q.push_back(t);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        clk_en    = 1'b1;
        flush     = 1'b0;
        cfg_wr    = 1'b0;
        cfg_mask  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = '0;
        checks    = 0;
        errors    = 0;
        hs_total  = 0;
        accepted  = 0;
        got       = '0;
        tb_mask   = 7'h7F;

        // in, data, out_ready, clk_en | in_ready, out_valid, busy, stall
        vecs[0]  = '{1'b1, 17'h01234, 7'b0000001, 1'b1, 1'b1, 7'b0000000, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 17'h00000, 7'b0000001, 1'b1, 1'b0, 7'b0000101, 1'b1, 16'd0};
        vecs[2]  = '{1'b0, 17'h00000, 7'b0000001, 1'b1, 1'b0, 7'b0000100, 1'b1, 16'd0};
        vecs[3]  = '{1'b0, 17'h00000, 7'b0000001, 1'b1, 1'b0, 7'b0000100, 1'b1, 16'd1};
        vecs[4]  = '{1'b0, 17'h00000, 7'b0000001, 1'b1, 1'b0, 7'b0000100, 1'b1, 16'd2};
        vecs[5]  = '{1'b0, 17'h00000, 7'b0000101, 1'b1, 1'b1, 7'b0000100, 1'b1, 16'd3};
        vecs[6]  = '{1'b0, 17'h00000, 7'b0000000, 1'b1, 1'b1, 7'b0000000, 1'b0, 16'd0};
        vecs[7]  = '{1'b1, 17'h00BEE, 7'b0000100, 1'b1, 1'b1, 7'b0000000, 1'b0, 16'd0};
        vecs[8]  = '{1'b0, 17'h00000, 7'b0000100, 1'b1, 1'b0, 7'b0000101, 1'b1, 16'd0};
        vecs[9]  = '{1'b1, 17'h13579, 7'b0000101, 1'b0, 1'b0, 7'b0000000, 1'b1, 16'd0};
        vecs[10] = '{1'b1, 17'h13579, 7'b0000101, 1'b0, 1'b0, 7'b0000000, 1'b1, 16'd0};
        vecs[11] = '{1'b1, 17'h13579, 7'b0000101, 1'b0, 1'b0, 7'b0000000, 1'b1, 16'd0};
        vecs[12] = '{1'b1, 17'h13579, 7'b0000101, 1'b0, 1'b0, 7'b0000000, 1'b1, 16'd0};
        vecs[13] = '{1'b0, 17'h00000, 7'b0000101, 1'b1, 1'b1, 7'b0000001, 1'b1, 16'd0};
        vecs[14] = '{1'b0, 17'h00000, 7'b0000000, 1'b1, 1'b1, 7'b0000000, 1'b0, 16'd0};

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_cfg_mask_q", cfg_mask_q, 7'h7F);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_stall_cnt", stall_cnt, 0);
        checkOutput("rst_cfg_err", cfg_err, 0);
        checkOutput("rst_out_data", out_data, 0);
        @(negedge clk);
        reset = 1'b0;

        // Full-rate streaming of ten tokens to all destinations.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, DW'(32'h000A5 + k), 7'h7F, 1'b1);
            checkOutput($sformatf("stream%0d_in_ready", k), in_ready, 1);
            checkOutput($sformatf("stream%0d_out_valid", k), out_valid, (k == 0) ? 0 : 7'h7F);
            tick();
        end
        applyStimulus(1'b0, '0, 7'h7F, 1'b1);
        checkOutput("stream_drain_out_valid", out_valid, 7'h7F);
        checkOutput("stream_drain_in_ready", in_ready, 1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("stream_idle_busy", busy, 0);
        checkOutput("stream_accepted", accepted, 10);
        checkOutput("stream_sb_empty", sb_q.size(), 0);

        cfg_wr   = 1'b1;
        cfg_mask = 7'b0000101;
        tick();
        cfg_wr  = 1'b0;
        tb_mask = 7'b0000101;

        // Partial acceptance with a slow destination, then clk_en freeze mid-token.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].data, vecs[i].ordy, vecs[i].ce);
            if (i == 0) checkOutput("cfg_mask_write", cfg_mask_q, 7'b0000101);
            checkOutput($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_ir);
            checkOutput($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
            checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            checkOutput($sformatf("vec%0d_stall_cnt", i), stall_cnt, vecs[i].exp_stall);
            tick();
        end

        // Empty mask: tokens are swallowed without ever reaching a destination.
        cfg_wr   = 1'b1;
        cfg_mask = '0;
        applyStimulus(1'b0, '0, '0, 1'b1);
        tick();
        cfg_wr   = 1'b0;
        tb_mask  = '0;
        accepted = 0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, DW'(32'h00200 + k), 7'h7F, 1'b1);
            checkOutput($sformatf("zmask%0d_in_ready", k), in_ready, 1);
            checkOutput($sformatf("zmask%0d_out_valid", k), out_valid, 0);
            checkOutput($sformatf("zmask%0d_busy", k), busy, 0);
            tick();
        end
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("zmask_busy", busy, 0);
        checkOutput("zmask_accepted", accepted, 5);

        // Config write while FULL is rejected; flush clears the error and the token.
        cfg_wr   = 1'b1;
        cfg_mask = 7'h7F;
        tick();
        cfg_wr  = 1'b0;
        tb_mask = 7'h7F;
        applyStimulus(1'b1, 17'h0CAFE, '0, 1'b1);
        tick();
        cfg_wr   = 1'b1;
        cfg_mask = 7'h03;
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("cfgerr_busy", busy, 1);
        tick();
        cfg_wr = 1'b0;
        flush  = 1'b1;
        applyStimulus(1'b1, 17'h01111, 7'h7F, 1'b1);
        checkOutput("cfgerr_mask_kept", cfg_mask_q, 7'h7F);
        checkOutput("cfgerr_sticky", cfg_err, 1);
        checkOutput("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("flush_busy", busy, 0);
        checkOutput("flush_cfg_err", cfg_err, 0);
        checkOutput("flush_stall_cnt", stall_cnt, 0);
        checkOutput("flush_mask_kept", cfg_mask_q, 7'h7F);
        cfg_wr   = 1'b1;
        cfg_mask = 7'h03;
        tick();
        cfg_wr  = 1'b0;
        tb_mask = 7'h03;
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("cfg_after_flush", cfg_mask_q, 7'h03);

        // Long stall saturates the counter; async reset then drops the token at once.
        applyStimulus(1'b1, 17'h1FFFF, '0, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1);
        tick();
        repeat (70000) @(negedge clk);
        #1;
        checkOutput("stall_saturated", stall_cnt, 16'hFFFF);
        checkOutput("stall_busy", busy, 1);
        checkOutput("stall_out_valid", out_valid, 7'h03);
        reset = 1'b1;
        #1;
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_in_ready", in_ready, 1);
        checkOutput("async_rst_out_valid", out_valid, 0);
        checkOutput("async_rst_cfg_mask_q", cfg_mask_q, 7'h7F);
        checkOutput("async_rst_stall_cnt", stall_cnt, 0);
        checkOutput("async_rst_out_data", out_data, 0);
        checkOutput("async_rst_cfg_err", cfg_err, 0);
        sb_q.delete();
        got     = '0;
        tb_mask = 7'h7F;
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(1'b1, 17'h15A5A, 7'h7F, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 7'h7F, 1'b1);
        checkOutput("post_rst_out_valid", out_valid, 7'h7F);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("final_sb_empty", sb_q.size(), 0);
        checkOutput("final_handshake_total", hs_total, 81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
